// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  // Index width for an n-entry vector, never narrower than one bit.
  function automatic int idx_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Round-robin pick: first set request strictly after last_i, wrapping around.
// Latency: combinational.
// Backpressure: none; any_o low when no request is set.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]          req_i,
  input  logic [idx_w(NREQ)-1:0]   last_i,
  output logic [idx_w(NREQ)-1:0]   next_o,
  output logic                     any_o
);

  localparam int IW = idx_w(NREQ);

  // Walk offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    next_o = last_i;
    any_o  = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_i[IW'((int'(last_i) + k) % NREQ)]) begin
        next_o = IW'((int'(last_i) + k) % NREQ);
        any_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers.
// Latency: valid in cycle 0 -> ready in cycle 1 -> fifo_write_en in cycle 2.
// Backpressure: full, or almost_full with a write in flight, drops req_ready and holds the grant.
// Optional feature: FIFO_ARB_BURST_EN enables multi-word grants of up to BURST words.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    fifo_write_en,
  output logic [WIDTH-1:0]        fifo_write_data,
  input  logic                    fifo_full,
  input  logic                    fifo_almost_full,
  output logic [idx_w(NREQ)-1:0]  grant_id,
  output logic                    busy
);

  localparam int IW = idx_w(NREQ);

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    grant_q, grant_d;
  logic [IW-1:0]    last_q, last_d;
  logic             wen_q, wen_d;
  logic [WIDTH-1:0] wdat_q, wdat_d;

  logic             stall;
  logic             accept;
  logic             last_word;
  logic             pick_any;
  logic [IW-1:0]    pick_idx;
  logic [WIDTH-1:0] grant_word;

`ifdef FIFO_ARB_BURST_EN
  localparam int CW = $clog2(BURST) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  assign last_word = (cnt_q == CW'(BURST - 1));
`else
  // Single-word grants; BURST has no effect in this build.
  assign last_word = 1'b1 | (BURST == 0);
`endif

  // The registered write in flight consumes the last free slot when almost_full.
  assign stall  = fifo_full | (fifo_almost_full & wen_q);
  assign accept = (state_q == XFER) & req_valid[grant_q] & ~stall;

  assign fifo_write_en   = wen_q;
  assign fifo_write_data = wdat_q;
  assign grant_id        = grant_q;
  assign busy            = (state_q == XFER);

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i  (req_valid),
    .last_i (last_q),
    .next_o (pick_idx),
    .any_o  (pick_any)
  );

  // Select the granted requester's data slice.
  always_comb begin
    grant_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q == IW'(i)) grant_word = req_data[i*WIDTH +: WIDTH];
    end
  end

  // Only the grantee sees ready, and only while the FIFO can take a word.
  always_comb begin
    req_ready = '0;
    if ((state_q == XFER) && !stall) req_ready[grant_q] = 1'b1;
  end

  // Next-state logic: arbitration in IDLE, word forwarding and grant release in XFER.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wen_d   = 1'b0;
    wdat_d  = wdat_q;
`ifdef FIFO_ARB_BURST_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = XFER;
`ifdef FIFO_ARB_BURST_EN
          cnt_d   = '0;
`endif
        end
      end
      XFER: begin
        if (accept) begin
          wen_d  = 1'b1;
          wdat_d = grant_word;
          if (last_word) begin
            state_d = IDLE;
            last_d  = grant_q;
          end
`ifdef FIFO_ARB_BURST_EN
          else begin
            cnt_d = cnt_q + CW'(1);
          end
`endif
        end else if (!stall && !req_valid[grant_q]) begin
          // Producer went quiet: release the grant early.
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any pending write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NREQ - 1);
      wen_q   <= 1'b0;
      wdat_q  <= '0;
`ifdef FIFO_ARB_BURST_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wen_q   <= wen_d;
      wdat_q  <= wdat_d;
`ifdef FIFO_ARB_BURST_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized bench for fifo_write_arbiter against a transaction-level reference model.
// Latency: checks every cycle, one cycle of model state per clock.
// Backpressure: a small FIFO occupancy model drives full/almost_full.
module tb_fifo_write_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int BURST = 4;
  localparam int DEPTH = 4;
`ifdef FIFO_ARB_BURST_EN
  localparam int LIMIT = BURST;
`else
  localparam int LIMIT = 1;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_write_en;
  logic [WIDTH-1:0]      fifo_write_data;
  logic                  fifo_full;
  logic                  fifo_almost_full;
  logic [1:0]            grant_id;
  logic                  busy;

  always #5 clk = ~clk;

  fifo_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .fifo_write_en    (fifo_write_en),
    .fifo_write_data  (fifo_write_data),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .grant_id         (grant_id),
    .busy             (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: who holds the grant, how many words it has moved, last write.
  bit             m_busy;
  int             m_gid, m_last, m_words;
  bit             m_wen;
  logic [7:0]     m_wdat;

  // Producers.
  bit             pv [NREQ];
  logic [7:0]     pd [NREQ];
  bit             en [NREQ];
  int             acc_cnt [NREQ];
  int             drop_after [NREQ];
  int             vprob;

  // FIFO occupancy; drain_mode 0 = none, 1 = every cycle, 2 = random.
  int             fifo_cnt;
  int             drain_mode;

  // Observations for directed checks.
  int             grants[$];
  int             words[$];
  bit             prev_busy;
  logic [NREQ-1:0] obs_ready;
  bit             obs_wen;
  logic [7:0]     obs_wdat;
  int             obs_gid;
  int             n_writes;

  task automatic drive_inputs();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = pv[i];
      req_data[i*WIDTH +: WIDTH] = pd[i];
    end
    fifo_full        = (fifo_cnt == DEPTH);
    fifo_almost_full = (fifo_cnt == DEPTH - 1);
  endtask

  task automatic clear_stats();
    grants.delete();
    words.delete();
    prev_busy = 1'b0;
    n_writes  = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_wr_en", fifo_write_en, 0);
    chk("rst_wr_data", fifo_write_data, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", busy, 0);
    for (int i = 0; i < NREQ; i++) begin
      pv[i] = 1'b0; pd[i] = '0; en[i] = 1'b0;
      acc_cnt[i] = 0; drop_after[i] = 1 << 30;
    end
    vprob = 0;
    fifo_cnt = 0;
    drain_mode = 1;
    drive_inputs();
    repeat (2) @(negedge clk);
    m_busy = 1'b0; m_gid = 0; m_last = NREQ - 1; m_words = 0;
    m_wen = 1'b0; m_wdat = '0;
    clear_stats();
    rst = 1'b0;
  endtask

  // One clock: drive, compare against the model, advance model, FIFO and producers.
  task automatic cycle();
    logic [NREQ-1:0] acc, exp_ready;
    bit         stall, drain, n_busy, n_wen, found;
    int         n_gid, n_last, n_words, cand;
    logic [7:0] n_wdat;

    drive_inputs();
    #1;
    stall = fifo_full || (fifo_almost_full && m_wen);
    exp_ready = '0;
    if (m_busy && !stall) exp_ready[m_gid] = 1'b1;
    chk("req_ready", req_ready, exp_ready);
    chk("busy", busy, m_busy);
    chk("grant_id", grant_id, m_gid);
    chk("wr_en", fifo_write_en, m_wen);
    chk("wr_data", fifo_write_data, m_wdat);
    chk("no_overflow", fifo_write_en && (fifo_cnt == DEPTH), 0);

    obs_ready = req_ready;
    obs_wen   = fifo_write_en;
    obs_wdat  = fifo_write_data;
    obs_gid   = grant_id;
    if (fifo_write_en) n_writes++;
    acc = req_valid & req_ready;
    if (busy && !prev_busy) begin
      grants.push_back(int'(grant_id));
      words.push_back(0);
    end
    if (acc != 0 && words.size() > 0) words[words.size()-1]++;
    prev_busy = busy;

    // Model: round-robin search from the last grantee, grant ends on limit or idle producer.
    n_busy = m_busy; n_gid = m_gid; n_last = m_last; n_words = m_words;
    n_wen = 1'b0; n_wdat = m_wdat;
    if (!m_busy) begin
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
        cand = (m_last + k) % NREQ;
        if (!found && req_valid[cand]) begin
          found = 1'b1; n_gid = cand; n_busy = 1'b1; n_words = 0;
        end
      end
    end else if (req_valid[m_gid] && !stall) begin
      n_wen = 1'b1; n_wdat = pd[m_gid]; n_words = m_words + 1;
      if (n_words == LIMIT) begin n_busy = 1'b0; n_last = m_gid; end
    end else if (!stall) begin
      n_busy = 1'b0; n_last = m_gid;
    end

    drain = (fifo_cnt > 0) && ((drain_mode == 1) || (drain_mode == 2 && $urandom_range(0, 1) == 1));
    @(posedge clk);
    fifo_cnt = fifo_cnt + (obs_wen ? 1 : 0) - (drain ? 1 : 0);
    if (fifo_cnt > DEPTH) fifo_cnt = DEPTH;
    m_busy = n_busy; m_gid = n_gid; m_last = n_last; m_words = n_words;
    m_wen = n_wen; m_wdat = n_wdat;
    @(negedge clk);

    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) acc_cnt[i]++;
      if (!(pv[i] && !acc[i])) begin
        pv[i] = en[i] && (acc_cnt[i] < drop_after[i]) && ($urandom_range(0, 99) < vprob);
        pd[i] = 8'($urandom);
      end
    end
  endtask

  initial begin
    bit found;
    #2;

    // Single word from requester 0: ready in cycle 1, write in cycle 2.
    do_reset();
    pv[0] = 1'b1; pd[0] = 8'hA5;
    cycle();
    chk("t1_c0_ready", obs_ready, 4'b0000);
    cycle();
    chk("t1_c1_ready", obs_ready, 4'b0001);
    cycle();
    chk("t1_c2_wr_en", obs_wen, 1);
    chk("t1_c2_wr_data", obs_wdat, 8'hA5);
    chk("t1_c2_grant", obs_gid, 0);
    repeat (3) cycle();
    chk("t1_writes", n_writes, 1);

    // All requesters continuously valid: grants rotate, LIMIT words each.
    do_reset();
    for (int i = 0; i < NREQ; i++) en[i] = 1'b1;
    vprob = 100;
    for (int i = 0; i < NREQ; i++) begin pv[i] = 1'b1; pd[i] = 8'($urandom); end
    repeat (6 * (LIMIT + 1) + 2) cycle();
    chk("t2_grant_count", grants.size() >= 5, 1);
    for (int i = 0; i < 5 && i < grants.size(); i++) begin
      chk("t2_rr_order", grants[i], i % NREQ);
      chk("t2_burst_len", words[i], LIMIT);
    end

    // One free slot: exactly one word lands, then ready stays low until drained.
    do_reset();
    en[0] = 1'b1; vprob = 100; pv[0] = 1'b1; pd[0] = 8'h3C;
    fifo_cnt = DEPTH - 1; drain_mode = 0;
    repeat (10) cycle();
    chk("t3_af_writes", n_writes, 1);
    chk("t3_af_ready_low", obs_ready, 4'b0000);
    drain_mode = 1;
    repeat (10) cycle();
    chk("t3_resumed", n_writes > 1, 1);

    // Requester 2 drops valid after two words; requester 3 is next.
    do_reset();
    en[2] = 1'b1; en[3] = 1'b1; vprob = 100; drop_after[2] = 2;
    pv[2] = 1'b1; pd[2] = 8'h22; pv[3] = 1'b1; pd[3] = 8'h33;
    repeat (16) cycle();
    chk("t4_grant_count", grants.size() >= 2, 1);
    chk("t4_first_grant", grants.size() > 0 ? grants[0] : -1, 2);
    chk("t4_first_words", words.size() > 0 ? words[0] : -1, (LIMIT < 2) ? LIMIT : 2);
    chk("t4_second_grant", grants.size() > 1 ? grants[1] : -1, 3);

    // Reset with a write in flight: it is dropped and requester 0 wins afterwards.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin en[i] = 1'b1; pv[i] = 1'b1; end
    vprob = 100;
    repeat (LIMIT + 3) cycle();
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      cycle();
      if (fifo_write_en) found = 1'b1;
    end
    chk("t5_setup_wr_pending", found, 1);
    do_reset();
    for (int i = 0; i < NREQ; i++) begin en[i] = 1'b1; pv[i] = 1'b1; end
    vprob = 100;
    repeat (6) cycle();
    chk("t5_first_grant", grants.size() > 0 ? grants[0] : -1, 0);

    // Random traffic with random FIFO draining.
    do_reset();
    for (int i = 0; i < NREQ; i++) en[i] = 1'b1;
    vprob = 60; drain_mode = 2;
    repeat (1500) cycle();
    vprob = 25; drain_mode = 1;
    repeat (500) cycle();
    vprob = 90; drain_mode = 2;
    repeat (1000) cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
